// File: rtl/spi_main_ctrl.sv
// SPI main controller: sends a mode-tagged write frame, idles cs for a gap,
// then clocks in a 128-bit read frame from the subordinate.
module spi_main_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [255:0] data_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [127:0] rx_data,
   output logic         cs,
   output logic         sclk,
   output logic         mosi,
   input  logic         miso
);

   typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, FIN} state_t;
   // A phase is: lead half-period, N sclk periods, then a tail half-period before cs rises.
   typedef enum logic [1:0] {SEG_LEAD, SEG_RUN, SEG_TAIL} seg_t;

   state_t       state, state_nxt;
   seg_t         seg;
   logic [7:0]   div_cnt;
   logic [15:0]  gap_cnt;
   logic [8:0]   bit_cnt;
   logic [8:0]   last_bit;
   logic [1:0]   mode_q;
   logic [256:0] tx_sh;
   logic         tick, phase_end, gap_end, accept, reject;

   assign tick      = (div_cnt == 8'(CLK_DIV - 1));
   assign phase_end = tick && (seg == SEG_TAIL);
   assign gap_end   = (gap_cnt == 16'(GAP_CYC - 1));

   always_comb begin
      last_bit = 9'd127;
      if (state == WRITE) begin
         case (mode_q)
            2'b00:   last_bit = 9'd129;
            2'b01:   last_bit = 9'd197;
            default: last_bit = 9'd257;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (mode == 2'b11) begin
                  reject = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = WRITE;
               end
            end
         end
         WRITE: begin
            busy = 1'b1;
            if (phase_end) state_nxt = GAP;
         end
         GAP: begin
            busy = 1'b1;
            if (gap_end) state_nxt = READ;
         end
         READ: begin
            busy = 1'b1;
            if (phase_end) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs      <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         err     <= 1'b0;
         rx_data <= '0;
         mode_q  <= '0;
         tx_sh   <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         bit_cnt <= '0;
         seg     <= SEG_LEAD;
      end else begin
         err <= reject;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mode_q  <= mode;
                  tx_sh   <= {mode[0], data_in};
                  mosi    <= mode[1];
                  cs      <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  seg     <= SEG_LEAD;
               end
            end
            WRITE, READ: begin
               div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
               if (tick) begin
                  unique case (seg)
                     SEG_LEAD: begin
                        sclk <= 1'b1;
                        seg  <= SEG_RUN;
                     end
                     SEG_RUN: begin
                        if (sclk) begin
                           sclk <= 1'b0;
                           if (state == READ) rx_data <= {rx_data[126:0], miso};
                        end else if (bit_cnt == last_bit) begin
                           seg <= SEG_TAIL;
                        end else begin
                           // Next bit goes out on the same edge that raises sclk.
                           sclk    <= 1'b1;
                           bit_cnt <= bit_cnt + 9'd1;
                           if (state == WRITE) begin
                              mosi  <= tx_sh[256];
                              tx_sh <= tx_sh << 1;
                           end
                        end
                     end
                     SEG_TAIL: begin
                        cs      <= 1'b1;
                        mosi    <= 1'b0;
                        seg     <= SEG_LEAD;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                     end
                     default: seg <= SEG_LEAD;
                  endcase
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 16'd1;
               if (gap_end) begin
                  cs      <= 1'b0;
                  div_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
